// File: rtl/scaler_linear_v_if.sv
// Pixel stream bundle: one pixel per clock with de/hs/vs framing, no backpressure.
interface scaler_linear_v_if #(
  parameter int PIXEL_WIDTH = 12
);
  logic [PIXEL_WIDTH-1:0] data;
  logic                   de;
  logic                   hs;
  logic                   vs;

  modport master (output data, de, hs, vs);
  modport slave  (input  data, de, hs, vs);
endinterface

// File: rtl/scaler_linear_v.sv
// Vertical linear downscaler: blends each selected input line with the line above it
// using a one-line buffer, producing fewer output lines than input lines.
module scaler_linear_v #(
  parameter int PIXEL_STEP  = 4096,
  parameter int PIXEL_WIDTH = 12,
  parameter int COE_WIDTH   = 10,
  parameter int MAX_WIDTH   = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       scale_step,
  scaler_linear_v_if.slave  i_pix,
  scaler_linear_v_if.master o_pix
);
  localparam int CNT_W     = 24;
  localparam int COE_SHIFT = $clog2(PIXEL_STEP) - (COE_WIDTH - 1);
  localparam int ADDR_W    = $clog2(MAX_WIDTH);
  localparam int COL_W     = ADDR_W + 1;
  localparam int PROD_W    = PIXEL_WIDTH + COE_WIDTH;
  localparam int SUM_W     = PROD_W + 1;
  localparam logic [CNT_W-1:0]     STEP_ONE = CNT_W'(PIXEL_STEP);
  localparam logic [COE_WIDTH-1:0] COE_ONE  = COE_WIDTH'(2 ** (COE_WIDTH - 1));
  localparam logic [SUM_W-1:0]     ROUND    = SUM_W'(2 ** (COE_WIDTH - 2));
  localparam logic [SUM_W-1:0]     PIX_MAX  = SUM_W'(2 ** PIXEL_WIDTH - 1);

  typedef enum logic {WAIT_FRAME, ACTIVE} state_t;

  state_t                 r_state, w_stateNext;
  logic [CNT_W-1:0]       r_step, r_cntI, r_cntO;
  logic [CNT_W-1:0]       w_step, w_cntI, w_cntO, w_cntOBase, w_f;
  logic                   r_firstLine, r_emit, w_firstLine, w_emit;
  logic [COE_WIDTH-1:0]   r_coeCur, w_coeCur;
  logic [COL_W-1:0]       r_col, w_col;
  logic [ADDR_W-1:0]      w_addr;
  logic                   w_frameStart, w_lineStart, w_accept, w_lineEmit;
  logic                   w_colInRange, w_prevZero;

  logic [PIXEL_WIDTH-1:0] r_lineBuf [MAX_WIDTH];
  logic [PIXEL_WIDTH-1:0] r_prevRd;

  logic                   r_s1Valid, r_s1Hs, r_s1Vs, r_s1PrevZero;
  logic [PIXEL_WIDTH-1:0] r_s1Cur;
  logic [COE_WIDTH-1:0]   r_s1Coe;
  logic                   r_s2Valid, r_s2Hs, r_s2Vs;
  logic [PROD_W-1:0]      r_s2ProdPrev, r_s2ProdCur;
  logic                   r_s3Valid, r_s3Hs, r_s3Vs;
  logic [SUM_W-1:0]       r_s3Sum;
  logic [PIXEL_WIDTH-1:0] r_do;
  logic                   r_de, r_hs, r_vs;

  logic [PIXEL_WIDTH-1:0] w_prev, w_outPix;
  logic [COE_WIDTH-1:0]   w_coePrev;
  logic [SUM_W-1:0]       w_sumPix;

  assign w_frameStart = i_pix.de & i_pix.hs & i_pix.vs;
  assign w_lineStart  = i_pix.de & i_pix.hs & ~i_pix.vs & (r_state == ACTIVE);
  assign w_accept     = i_pix.de & (w_frameStart | (r_state == ACTIVE));
  assign w_lineEmit   = w_accept & w_emit;
  assign w_col        = i_pix.hs ? '0 : r_col;
  assign w_addr       = w_col[ADDR_W-1:0];
  assign w_colInRange = (w_col < COL_W'(MAX_WIDTH));
  assign w_prevZero   = w_firstLine | (w_coeCur == COE_ONE) | ~w_colInRange;

  // Line decision: compare output position against the current input line position
  always_comb begin
    w_stateNext = r_state;
    w_step      = r_step;
    w_cntI      = r_cntI;
    w_cntO      = r_cntO;
    w_cntOBase  = r_cntO;
    w_firstLine = r_firstLine;
    w_emit      = r_emit;
    w_coeCur    = r_coeCur;
    w_f         = '0;
    if (w_frameStart) begin
      w_stateNext = ACTIVE;
      w_step      = ({8'd0, scale_step} < STEP_ONE) ? STEP_ONE : {8'd0, scale_step};
      w_cntI      = '0;
      w_cntOBase  = '0;
      w_firstLine = 1'b1;
    end else if (w_lineStart) begin
      w_cntI      = r_cntI + STEP_ONE;
      w_firstLine = 1'b0;
    end
    if (w_frameStart || w_lineStart) begin
      w_emit   = (w_cntOBase <= w_cntI);
      w_f      = w_cntOBase - w_cntI + STEP_ONE;
      w_coeCur = w_emit ? COE_WIDTH'(w_f >> COE_SHIFT) : '0;
      w_cntO   = w_emit ? w_cntOBase + w_step : w_cntOBase;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= WAIT_FRAME;
      r_step      <= STEP_ONE;
      r_cntI      <= '0;
      r_cntO      <= '0;
      r_firstLine <= 1'b1;
      r_emit      <= 1'b0;
      r_coeCur    <= '0;
      r_col       <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_step      <= w_step;
      r_cntI      <= w_cntI;
      r_cntO      <= w_cntO;
      r_firstLine <= w_firstLine;
      r_emit      <= w_emit;
      r_coeCur    <= w_coeCur;
      if (w_accept) r_col <= w_colInRange ? w_col + COL_W'(1) : w_col;
    end
  end

  // Read-before-write: the old entry is the same column of the previous line
  always_ff @(posedge clk) begin
    if (w_accept && w_colInRange) begin
      r_prevRd          <= r_lineBuf[w_addr];
      r_lineBuf[w_addr] <= i_pix.data;
    end
  end

  assign w_prev    = r_s1PrevZero ? '0 : r_prevRd;
  assign w_coePrev = COE_ONE - r_s1Coe;
  assign w_sumPix  = r_s3Sum >> (COE_WIDTH - 1);
  assign w_outPix  = (w_sumPix > PIX_MAX) ? '1 : w_sumPix[PIXEL_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid    <= 1'b0;
      r_s1Hs       <= 1'b0;
      r_s1Vs       <= 1'b0;
      r_s1PrevZero <= 1'b1;
      r_s1Cur      <= '0;
      r_s1Coe      <= '0;
      r_s2Valid    <= 1'b0;
      r_s2Hs       <= 1'b0;
      r_s2Vs       <= 1'b0;
      r_s2ProdPrev <= '0;
      r_s2ProdCur  <= '0;
      r_s3Valid    <= 1'b0;
      r_s3Hs       <= 1'b0;
      r_s3Vs       <= 1'b0;
      r_s3Sum      <= '0;
      r_do         <= '0;
      r_de         <= 1'b0;
      r_hs         <= 1'b0;
      r_vs         <= 1'b0;
    end else begin
      r_s1Valid    <= w_lineEmit;
      r_s1Hs       <= w_lineEmit & i_pix.hs;
      r_s1Vs       <= w_lineEmit & w_frameStart;
      r_s1PrevZero <= w_prevZero;
      r_s1Cur      <= i_pix.data;
      r_s1Coe      <= w_coeCur;
      r_s2Valid    <= r_s1Valid;
      r_s2Hs       <= r_s1Hs;
      r_s2Vs       <= r_s1Vs;
      r_s2ProdPrev <= PROD_W'(w_prev) * PROD_W'(w_coePrev);
      r_s2ProdCur  <= PROD_W'(r_s1Cur) * PROD_W'(r_s1Coe);
      r_s3Valid    <= r_s2Valid;
      r_s3Hs       <= r_s2Hs;
      r_s3Vs       <= r_s2Vs;
      r_s3Sum      <= SUM_W'(r_s2ProdPrev) + SUM_W'(r_s2ProdCur) + ROUND;
      r_de         <= r_s3Valid;
      r_hs         <= r_s3Hs;
      r_vs         <= r_s3Vs;
      if (r_s3Valid) r_do <= w_outPix;
    end
  end

  assign o_pix.data = r_do;
  assign o_pix.de   = r_de;
  assign o_pix.hs   = r_hs;
  assign o_pix.vs   = r_vs;
endmodule

// File: tb/tb_scaler_linear_v.sv
// Randomized bench for scaler_linear_v against a line-position model of vertical blending.
module tb_scaler_linear_v;
  localparam int PW = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] scaleStep;

  scaler_linear_v_if #(.PIXEL_WIDTH(PW)) inIf ();
  scaler_linear_v_if #(.PIXEL_WIDTH(PW)) outIf ();

  scaler_linear_v #(
    .PIXEL_STEP(4096), .PIXEL_WIDTH(PW), .COE_WIDTH(10), .MAX_WIDTH(2048)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scale_step(scaleStep), .i_pix(inIf), .o_pix(outIf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit de;
    bit hs;
    bit vs;
    int data;
  } expect_t;

  expect_t expQ[$];
  int      checks = 0;
  int      errors = 0;
  bit      inFrame, mEmit;
  int      mStep, mLine, mCol, mF, lastData;
  int      prevLine[64];
  int      curLine[64];

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Output line k sits at k*step; input line n covers (n-1)*PS .. n*PS
  function automatic void modelStartLine();
    int k;
    if (mLine == 0) begin
      mEmit = 1'b1;
      mF    = 4096;
    end else begin
      k     = (mLine * 4096) / mStep;
      mEmit = (k * mStep) > ((mLine - 1) * 4096);
      mF    = k * mStep - mLine * 4096 + 4096;
    end
  endfunction

  task automatic cycleStep(input bit de, input bit hs, input bit vs, input int data);
    expect_t e;
    int      coeCur, coePrev, prev, v;
    bit      frameStart;
    @(negedge clk);
    if (expQ.size() == 4) begin
      e = expQ.pop_front();
      checkOutput("de_o", int'(outIf.de), int'(e.de));
      checkOutput("hs_o", int'(outIf.hs), int'(e.hs));
      checkOutput("vs_o", int'(outIf.vs), int'(e.vs));
      checkOutput("do_o", int'(outIf.data), e.data);
    end
    inIf.de   = de;
    inIf.hs   = hs;
    inIf.vs   = vs;
    inIf.data = data[PW-1:0];
    frameStart = de && hs && vs;
    if (frameStart) begin
      inFrame = 1'b1;
      mStep   = (scaleStep < 16'd4096) ? 4096 : int'(scaleStep);
      mLine   = 0;
      modelStartLine();
    end else if (de && hs && inFrame) begin
      mLine++;
      prevLine = curLine;
      modelStartLine();
    end
    e.de   = 1'b0;
    e.hs   = 1'b0;
    e.vs   = 1'b0;
    e.data = lastData;
    if (de && inFrame) begin
      mCol = hs ? 0 : mCol + 1;
      if (mEmit) begin
        coeCur  = mF / 8;
        coePrev = 512 - coeCur;
        prev    = (mLine == 0 || coePrev == 0) ? 0 : prevLine[mCol];
        v       = (coePrev * prev + coeCur * data + 256) / 512;
        if (v > 4095) v = 4095;
        e.de     = 1'b1;
        e.hs     = hs;
        e.vs     = frameStart;
        e.data   = v;
        lastData = v;
      end
      curLine[mCol] = data;
    end
    expQ.push_back(e);
  endtask

  task automatic idleCycle();
    cycleStep(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 4095)));
  endtask

  // mode: 0 random, 1 ramp, 2 constant 100*line, 3 full-scale; gapMode: 0 none, 1 alternate, 2 random
  task automatic applyStimulus(input int step, input int width, input int lines, input int mode,
                               input int gapMode, input bit withVs, input int abortLine);
    bit aborted;
    int pix;
    aborted   = 1'b0;
    scaleStep = 16'(step);
    for (int l = 0; l < lines && !aborted; l++) begin
      for (int p = 0; p < width && !aborted; p++) begin
        case (mode)
          0:       pix = int'($urandom_range(0, 4095));
          1:       pix = (l * width + p) % 4096;
          2:       pix = 100 * l;
          default: pix = 4095;
        endcase
        cycleStep(1'b1, p == 0, withVs && l == 0 && p == 0, pix);
        if (l == abortLine && p == width / 2) begin
          #2 rst_n = 1'b0;
          inIf.de = 1'b0;
          #1;
          checkOutput("rst_async_do", int'(outIf.data), 0);
          checkOutput("rst_async_de", int'(outIf.de), 0);
          checkOutput("rst_async_hs", int'(outIf.hs), 0);
          checkOutput("rst_async_vs", int'(outIf.vs), 0);
          expQ.delete();
          inFrame  = 1'b0;
          lastData = 0;
          repeat (2) @(negedge clk);
          rst_n   = 1'b1;
          aborted = 1'b1;
        end else if (p < width - 1) begin
          if (gapMode == 1) idleCycle();
          else if (gapMode == 2) repeat ($urandom_range(0, 2)) idleCycle();
        end
      end
      if (!aborted) repeat (2 + $urandom_range(0, 2)) idleCycle();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    scaleStep = 16'd4096;
    inIf.data = '0;
    inIf.de   = 1'b0;
    inIf.hs   = 1'b0;
    inIf.vs   = 1'b0;
    inFrame   = 1'b0;
    mEmit     = 1'b0;
    mStep     = 4096;
    mLine     = 0;
    mCol      = 0;
    mF        = 4096;
    lastData  = 0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_do", int'(outIf.data), 0);
    checkOutput("reset_de", int'(outIf.de), 0);
    checkOutput("reset_hs", int'(outIf.hs), 0);
    checkOutput("reset_vs", int'(outIf.vs), 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] identity frame, ramp pixels");
    applyStimulus(4096, 8, 4, 1, 0, 1'b1, -1);
    $display("[TB] step 1.5, constant lines");
    applyStimulus(6144, 8, 6, 2, 0, 1'b1, -1);
    $display("[TB] reset during line 2, orphan lines, clean frame");
    applyStimulus(4096, 8, 4, 1, 0, 1'b1, 2);
    applyStimulus(4096, 8, 2, 1, 0, 1'b0, -1);
    applyStimulus(4096, 8, 4, 1, 0, 1'b1, -1);
    $display("[TB] step below 1.0 clamps to identity");
    applyStimulus(2048, 8, 4, 0, 0, 1'b1, -1);
    $display("[TB] alternating de gaps");
    applyStimulus(4096, 8, 4, 0, 1, 1'b1, -1);
    $display("[TB] full-scale pixels at step 1.5");
    applyStimulus(6144, 8, 6, 3, 0, 1'b1, -1);
    $display("[TB] random frames");
    for (int t = 0; t < 6; t++)
      applyStimulus(int'($urandom_range(0, 12288)), int'($urandom_range(2, 16)),
                    int'($urandom_range(2, 10)), 0, 2, 1'b1, -1);
    repeat (6) idleCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
